// File: rtl/mont_mul_resp_pkg.sv
// Shared types and sizing for the bit-serial radix-2 Montgomery multiplier.
package mont_pkg;
  localparam int W      = 260;
  localparam int N_ITER = 256;
  localparam int CNT_W  = 9;

  typedef enum logic [1:0] {IDLE, ITER, FINAL} state_t;
  typedef logic [W-1:0] bigint_t;
endpackage

// File: rtl/mont_mul_resp_if.sv
// start/done request-response bus between the exponentiation controller and the multiplier.
interface mont_mul_resp_if;
  import mont_pkg::*;
  logic    start;
  bigint_t a;
  bigint_t b;
  bigint_t m;
  bigint_t result;
  logic    done;

  modport master (output start, a, b, m, input result, done);
  modport slave  (input start, a, b, m, output result, done);
endinterface

// File: rtl/mont_mul_resp_step.sv
// One radix-2 Montgomery iteration: acc' = (acc + bit*b + q*m) / 2, with q chosen to clear bit 0.
module mont_step
  import mont_pkg::*;
(
  input  bigint_t acc,
  input  bigint_t b,
  input  bigint_t m,
  input  logic    bit_in,
  output bigint_t acc_next
);
  bigint_t t_add;
  bigint_t t_red;

  // Guard bits keep acc + b + m below 2^W, so no carry is lost.
  always_comb begin
    t_add    = acc + (bit_in ? b : '0);
    t_red    = t_add + (t_add[0] ? m : '0);
    acc_next = t_red >> 1;
  end
endmodule

// File: rtl/mont_mul_resp.sv
// Montgomery product responder: result = a*b*2^-N_ITER mod m, one multiplier bit per clock.
// Macro MONT_FINAL_SUB_EN adds the FINAL conditional-subtract state (result < m); without it result < 2m.
module mont_mul_resp
  import mont_pkg::*;
(
  input logic            clk,
  input logic            reset,
  mont_mul_resp_if.slave bus
);
  state_t           state, state_n;
  bigint_t          acc, acc_n;
  bigint_t          a_r, a_r_n;
  bigint_t          b_r, b_r_n;
  bigint_t          m_r, m_r_n;
  bigint_t          result, result_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             done, done_n;
  bigint_t          step_acc;

  mont_step u_step (
    .acc      (acc),
    .b        (b_r),
    .m        (m_r),
    .bit_in   (a_r[cnt]),
    .acc_next (step_acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      m_r    <= '0;
      result <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      a_r    <= a_r_n;
      b_r    <= b_r_n;
      m_r    <= m_r_n;
      result <= result_n;
      cnt    <= cnt_n;
      done   <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    a_r_n    = a_r;
    b_r_n    = b_r;
    m_r_n    = m_r;
    result_n = result;
    cnt_n    = cnt;
    done_n   = done;
    case (state)
      IDLE: begin
        if (bus.start) begin
          a_r_n   = bus.a;
          b_r_n   = bus.b;
          m_r_n   = bus.m;
          acc_n   = '0;
          cnt_n   = '0;
          done_n  = 1'b0;
          state_n = ITER;
        end else begin
          done_n = 1'b1;
        end
      end
      ITER: begin
        acc_n = step_acc;
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(N_ITER - 1)) begin
`ifdef MONT_FINAL_SUB_EN
          state_n = FINAL;
`else
          // Lazy reduction: hand back the raw accumulator, still < 2m.
          result_n = step_acc;
          done_n   = 1'b1;
          state_n  = IDLE;
`endif
        end
      end
`ifdef MONT_FINAL_SUB_EN
      FINAL: begin
        result_n = (acc >= m_r) ? acc - m_r : acc;
        done_n   = 1'b1;
        state_n  = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  assign bus.result = result;
  assign bus.done   = done;
endmodule

// File: tb/tb_mont_mul_resp.sv
// Directed and random checks of mont_mul_resp against an independent double-and-add / halving model.
module tb_mont_mul_resp;
  import mont_pkg::*;

`ifdef MONT_FINAL_SUB_EN
  localparam int LAT = N_ITER + 1;
`else
  localparam int LAT = N_ITER;
`endif

  logic clk = 1'b0;
  logic reset;
  mont_mul_resp_if bus();

  mont_mul_resp dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int      errors = 0;
  int      checks = 0;
  bigint_t P;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: (a*b mod p) by double-and-add, then 256 modular halvings for R^-1.
  function automatic bigint_t model(input bigint_t x, input bigint_t y);
    bigint_t r = '0;
    for (int i = N_ITER - 1; i >= 0; i--) begin
      r = r << 1;
      if (r >= P) r = r - P;
      if (x[i]) begin
        r = r + y;
        if (r >= P) r = r - P;
      end
    end
    for (int i = 0; i < N_ITER; i++)
      r = r[0] ? (r + P) >> 1 : r >> 1;
    return r;
  endfunction

  // Canonical form of a DUT result; an out-of-range lazy result becomes X so it never matches.
  function automatic bigint_t canon(input bigint_t r);
`ifdef MONT_FINAL_SUB_EN
    return r;
`else
    if (r >= (P << 1)) return 'x;
    return (r >= P) ? r - P : r;
`endif
  endfunction

  function automatic bigint_t rand_mod_p();
    bigint_t v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    v[W-1:255] = '0;
    if (v >= P) v = v - P;
    return v;
  endfunction

  // Pulse start, scramble the bus inputs while busy, and return done-after-accept and latency.
  task automatic run_op(input bigint_t av, input bigint_t bv, output logic d_acc, output int lat);
    bus.a = av;
    bus.b = bv;
    bus.m = P;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    d_acc = bus.done;
    bus.a = rand_mod_p();
    bus.b = rand_mod_p();
    bus.m = rand_mod_p() << 1;
    lat = -1;
    for (int n = 1; n <= LAT + 8; n++) begin
      tick();
      if (bus.done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic d;
    int   lat;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.a = '0; bus.b = '0; bus.m = '0;
    tick(); tick();
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++;
    if (bus.result !== '0) begin errors++; $display("FAIL reset_result got=%h want=0", bus.result); end
    // start already high in the first cycle after reset.
    reset = 1'b0;
    run_op(bigint_t'(38), bigint_t'(5), d, lat);
    checks++;
    if (d !== 1'b0) begin errors++; $display("FAIL first_cycle_start_done got=%b want=0", d); end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL first_cycle_start_lat got=%0d want=%0d", lat, LAT); end
    checks++;
    if (canon(bus.result) !== bigint_t'(5)) begin
      errors++; $display("FAIL first_cycle_start_result got=%h want=5", bus.result);
    end
  endtask

  task automatic test_directed();
    logic    d;
    int      lat;
    bigint_t exp_v [3];
    bigint_t av [3];
    bigint_t bv [3];
    av[0] = 38;   bv[0] = 5;     exp_v[0] = 5;
    av[1] = 1444; bv[1] = 1;     exp_v[1] = 38;
    av[2] = 0;    bv[2] = P - 1; exp_v[2] = 0;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], d, lat);
      checks++;
      if (d !== 1'b0) begin errors++; $display("FAIL directed%0d_busy got=%b want=0", i, d); end
      checks++;
      if (lat != LAT) begin errors++; $display("FAIL directed%0d_lat got=%0d want=%0d", i, lat, LAT); end
      checks++;
      if (canon(bus.result) !== exp_v[i]) begin
        errors++; $display("FAIL directed%0d_result got=%h want=%h", i, bus.result, exp_v[i]);
      end
    end
  endtask

  task automatic test_random();
    logic    d;
    int      lat;
    bigint_t av, bv, ev;
    for (int i = 0; i < 200; i++) begin
      av = rand_mod_p();
      bv = rand_mod_p();
      ev = model(av, bv);
      run_op(av, bv, d, lat);
      checks++;
      if (lat != LAT) begin errors++; $display("FAIL random%0d_lat got=%0d want=%0d", i, lat, LAT); end
      checks++;
      if (canon(bus.result) !== ev) begin
        errors++; $display("FAIL random%0d_result got=%h want=%h", i, bus.result, ev);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   rises = 0;
    int   first = -1;
    logic prev;
    bus.a = 38; bus.b = 5; bus.m = P;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.b = 7;
    prev = bus.done;
    for (int n = 1; n <= LAT + 20; n++) begin
      bus.start = (n == 10);
      tick();
      if (bus.done && !prev) begin
        rises++;
        if (first < 0) first = n;
      end
      prev = bus.done;
    end
    bus.start = 1'b0;
    checks++;
    if (rises != 1) begin errors++; $display("FAIL b2b_rises got=%0d want=1", rises); end
    checks++;
    if (first != LAT) begin errors++; $display("FAIL b2b_lat got=%0d want=%0d", first, LAT); end
    checks++;
    if (canon(bus.result) !== bigint_t'(5)) begin
      errors++; $display("FAIL b2b_result got=%h want=5", bus.result);
    end
  endtask

  task automatic test_reset_mid();
    logic d;
    int   lat;
    bus.a = 1444; bus.b = 3; bus.m = P;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 100; n++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.result !== '0) begin errors++; $display("FAIL abort_result got=%h want=0", bus.result); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b want=0", bus.done); end
    tick();
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL abort_idle_done got=%b want=1", bus.done); end
    run_op(bigint_t'(38), bigint_t'(7), d, lat);
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL abort_rerun_lat got=%0d want=%0d", lat, LAT); end
    checks++;
    if (canon(bus.result) !== bigint_t'(7)) begin
      errors++; $display("FAIL abort_rerun_result got=%h want=7", bus.result);
    end
  endtask

  initial begin
    P = '0;
    P[255] = 1'b1;
    P = P - 19;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
